posit_round_encode: RTL and testbench

Output stage of the posit add datapath. It takes the unnormalised mantissa sum, the combined scale (regime·2^ES + exponent), the sign and the special-case flags from the adder/alignment stage. It normalises the mantissa, splits the scale into regime and exponent fields, rounds to nearest-even, and emits an N-bit posit word. The block is a 2-stage pipeline with valid/ready handshakes on both sides and full throughput of 1 word per cycle.

---
 rtl/posit_pkg.sv | 35 +++
 rtl/posit_lzd.sv | 23 ++
 rtl/posit_round_encode.sv | 135 +++++++++++++
 tb/tb_posit_round_encode.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared posit widths, constants and stage-1 payload type
package posit_pkg;

  localparam int POSIT_N  = 8;
  localparam int POSIT_ES = 3;
  localparam int POSIT_RS = $clog2(POSIT_N);

  function automatic int scale_width(input int es, input int rs);
    return es + rs + 1;
  endfunction

  function automatic int max_scale(input int n, input int es);
    return (n - 2) << es;
  endfunction

  localparam int SCALE_W   = scale_width(POSIT_ES, POSIT_RS);
  localparam int MAX_SCALE = max_scale(POSIT_N, POSIT_ES);

  localparam logic [POSIT_N-1:0] POSIT_NAR    = {1'b1, {(POSIT_N-1){1'b0}}};
  localparam logic [POSIT_N-1:0] POSIT_ZERO   = '0;
  localparam logic [POSIT_N-1:0] POSIT_MAXPOS = {1'b0, {(POSIT_N-1){1'b1}}};
  localparam logic [POSIT_N-1:0] POSIT_MINPOS = {{(POSIT_N-1){1'b0}}, 1'b1};

  // Normalised stage-1 result; the hidden bit is implicit so only the
  // fraction below it is carried.
  typedef struct packed {
    logic                      sign;
    logic                      zero;
    logic                      nar;
    logic signed [SCALE_W:0]   scale;
    logic [POSIT_N-2:0]        frac;
    logic                      sticky;
  } s1_payload_t;

endpackage

// File: rtl/posit_lzd.sv
// rtl/posit_lzd.sv - leading-zero count with all-zero flag
// Ports: data  - word to scan (MSB first)
//        count - number of leading zeros (W when data is zero)
//        all_zero - data is zero
module posit_lzd #(
  parameter int W  = 9,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] count,
  output logic          all_zero
);

  // Scan upward so the highest set bit writes last and wins.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data[i]) count = CW'(W - 1 - i);
    end
    all_zero = ~|data;
  end

endmodule

// File: rtl/posit_round_encode.sv
// rtl/posit_round_encode.sv - posit adder output stage: normalise, round RNE, encode
// Ports: clk/reset (sync, active-high); in_valid/in_ready input handshake;
//        in_sign, in_zero, in_nar, in_scale (signed), in_mant (binary point
//        below bit N-1); out_valid/out_ready output handshake; out_posit word.
module posit_round_encode
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int RS = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_zero,
  input  logic          in_nar,
  input  logic [ES+RS:0] in_scale,
  input  logic [N:0]    in_mant,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
);

  localparam int SW  = scale_width(ES, RS);
  localparam int CW  = SW + 1;
  localparam int LZW = $clog2(N + 2);
  localparam int TW  = ES + N - 1;
  localparam int L   = N + TW;
  localparam logic signed [CW-1:0] MAXS = CW'(max_scale(N, ES));
  localparam logic signed [CW-1:0] MINS = -MAXS;
  localparam logic [L-1:0] ONES = '1;
  localparam logic [L-1:0] TOP1 = {1'b1, {(L-1){1'b0}}};

  logic        s1_valid, s2_valid, s1_adv, s2_adv;
  s1_payload_t s1_d, s1_q;
  logic [N-1:0] s2_d;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv && !reset;
  assign out_valid = s2_valid;

  // Stage 1: normalise so the hidden bit sits at N-1.
  logic [LZW-1:0]        lz;
  logic                  mant_zero;
  logic signed [CW-1:0]  sx;

  posit_lzd #(.W(N + 1), .CW(LZW)) u_lzd (
    .data     (in_mant),
    .count    (lz),
    .all_zero (mant_zero)
  );

  always_comb begin
    s1_d        = '0;
    sx          = {in_scale[SW-1], in_scale};
    s1_d.sign   = in_sign;
    s1_d.nar    = in_nar;
    s1_d.zero   = in_zero || mant_zero;
    if (in_mant[N]) begin
      // Sum reached [2,4): shift right, keep the lost bit as sticky.
      s1_d.frac   = in_mant[N-1:1];
      s1_d.sticky = in_mant[0];
      s1_d.scale  = sx + CW'(1);
    end else begin
      // Bit N is clear, so the shift needed is lz-1.
      s1_d.frac   = (N-1)'(in_mant << (lz - LZW'(1)));
      s1_d.scale  = sx + CW'(1) - {{(CW-LZW){1'b0}}, lz};
    end
  end

  // Stage 2: regime/exponent split, round to nearest even, sign.
  logic signed [CW-1:0] sc, k;
  logic [CW-1:0]        nk, reg_len;
  logic [ES-1:0]        e;
  logic [L-1:0]         regime, full;
  logic [N-2:0]         body;
  logic                 guard, sticky, rnd;
  logic [N-1:0]         rounded, mag;

  always_comb begin
    sc      = s1_q.scale;
    k       = sc >>> ES;
    nk      = -k;
    e       = sc[ES-1:0];
    regime  = '0;
    reg_len = '0;
    if (!k[CW-1]) begin
      regime  = ~(ONES >> (k + CW'(1)));
      reg_len = k + CW'(2);
    end else begin
      regime  = TOP1 >> nk;
      reg_len = CW'(1) + nk;
    end
    full    = regime | ({e, s1_q.frac, {N{1'b0}}} >> reg_len);
    body    = full[L-1 -: N-1];
    guard   = full[L-N];
    sticky  = (|full[L-N-1:0]) || s1_q.sticky;
    rnd     = guard && (sticky || body[0]);
    rounded = {1'b0, body} + N'(rnd);
    // Carry out of maxpos would land on NaR; a zero body would be zero.
    if (rounded[N-1])      rounded = POSIT_MAXPOS;
    else if (rounded == 0) rounded = POSIT_MINPOS;

    if (sc > MAXS)      mag = POSIT_MAXPOS;
    else if (sc < MINS) mag = POSIT_MINPOS;
    else                mag = rounded;

    if (s1_q.nar)       s2_d = POSIT_NAR;
    else if (s1_q.zero) s2_d = POSIT_ZERO;
    else if (s1_q.sign) s2_d = -mag;
    else                s2_d = mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_q      <= '0;
      out_posit <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        s1_q     <= s1_d;
      end
      if (s2_adv) begin
        s2_valid  <= s1_valid;
        out_posit <= s2_d;
      end
    end
  end

endmodule

// File: tb/tb_posit_round_encode.sv
// tb/tb_posit_round_encode.sv - scoreboard bench for posit_round_encode
module tb_posit_round_encode;

  localparam int N  = 8;
  localparam int ES = 3;
  localparam int RS = 3;
  localparam int SW = ES + RS + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sign = 1'b0;
  logic          in_zero = 1'b0;
  logic          in_nar = 1'b0;
  logic [SW-1:0] in_scale = '0;
  logic [N:0]    in_mant = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  out_posit;

  posit_round_encode #(.N(N), .ES(ES), .RS(RS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .in_scale  (in_scale),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  always #5 clk = ~clk;

  logic [N-1:0] exp_q[$];
  int           push_cyc_q[$];
  logic [N-1:0] cur_exp = '0;
  int           n_asserts = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           n_out = 0;
  bit           lat_check = 0;
  bit           ready_check = 0;
  bit           bp_mode = 0;
  bit           accepted = 0;
  bit           saw_stall = 0;
  bit           prev_stall = 0;
  logic [N-1:0] prev_posit = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  // One clock: sample at the falling edge, then return just after the rising edge.
  task automatic tick();
    logic [N-1:0] e;
    int pc;
    @(negedge clk);
    cyc++;
    accepted = 1'b0;
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_posit", out_posit, prev_posit);
    end
    if (ready_check)
      chk("in_ready_bp", in_ready, !(exp_q.size() == 2 && !out_ready));
    if (in_valid && !in_ready && !reset) saw_stall = 1'b1;
    if (out_valid && out_ready) begin
      n_out++;
      n_asserts++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_out cycle=%0d observed=%0h expected=none", cyc, out_posit);
      end
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        pc = push_cyc_q.pop_front();
        chk("posit", out_posit, e);
        if (lat_check) chk("latency", cyc - pc, 2);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      push_cyc_q.push_back(cyc);
      accepted = 1'b1;
    end
    prev_stall = out_valid && !out_ready && !reset;
    prev_posit = out_posit;
    @(posedge clk);
    #1;
    if (bp_mode) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
  endtask

  task automatic send(input logic s, input logic z, input logic n, input int scale,
                      input logic [N:0] m, input logic [N-1:0] expv);
    int guard = 0;
    in_sign  = s;
    in_zero  = z;
    in_nar   = n;
    in_scale = SW'(scale);
    in_mant  = m;
    cur_exp  = expv;
    in_valid = 1'b1;
    do begin
      tick();
      guard++;
    end while (!accepted && guard < 50);
    chk("accept_timeout", accepted, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      tick();
      guard++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic run(input logic s, input logic z, input logic n, input int scale,
                     input logic [N:0] m, input logic [N-1:0] expv);
    send(s, z, n, scale, m, expv);
    drain();
  endtask

  initial begin
    int base;
    // Reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_posit", out_posit, 0);
    reset = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Directed encodes with out_ready held high
    lat_check = 1;
    run(0, 0, 0,   0, 9'h080, 8'h40);
    run(1, 0, 0,   0, 9'h080, 8'hC0);
    run(0, 0, 0,   1, 9'h080, 8'h44);
    run(0, 0, 0,   0, 9'h100, 8'h44);
    run(0, 0, 0,   2, 9'h040, 8'h44);
    run(0, 0, 0,   0, 9'h090, 8'h40);
    run(0, 0, 0,   0, 9'h0B0, 8'h42);
    run(0, 0, 0,   0, 9'h091, 8'h41);
    run(0, 0, 0,   0, 9'h121, 8'h45);
    run(0, 0, 0,   0, 9'h120, 8'h44);
    run(1, 0, 0,   0, 9'h0B0, 8'hBE);
    run(0, 0, 0,  -1, 9'h080, 8'h3C);
    run(0, 0, 0,   8, 9'h080, 8'h60);
    run(0, 0, 0,  44, 9'h080, 8'h7E);
    run(0, 0, 0,  48, 9'h080, 8'h7F);
    run(0, 0, 0, -48, 9'h080, 8'h01);
    run(0, 0, 0,  60, 9'h080, 8'h7F);
    run(0, 0, 0, -60, 9'h080, 8'h01);
    run(0, 1, 0,   3, 9'h080, 8'h00);
    run(1, 1, 0,   3, 9'h0A0, 8'h00);
    run(0, 0, 0,   5, 9'h000, 8'h00);
    run(0, 1, 1,   0, 9'h080, 8'h80);
    run(1, 0, 1,   7, 9'h000, 8'h80);
    lat_check = 0;

    // Backpressure stream: out_ready toggles 1,0,0,1 while words stream in
    bp_mode     = 1;
    ready_check = 1;
    saw_stall   = 0;
    base        = n_out;
    send(0, 0, 0,  0, 9'h080, 8'h40);
    send(0, 0, 0,  1, 9'h080, 8'h44);
    send(0, 0, 0, -1, 9'h080, 8'h3C);
    send(0, 0, 0,  8, 9'h080, 8'h60);
    send(1, 0, 0,  0, 9'h0B0, 8'hBE);
    send(0, 0, 0,  0, 9'h121, 8'h45);
    drain();
    chk("stream_count", n_out - base, 6);
    chk("stream_saw_stall", saw_stall, 1);
    bp_mode     = 0;
    ready_check = 0;

    // Reset with two words in flight
    out_ready = 1'b0;
    send(0, 0, 0, 0, 9'h080, 8'h40);
    send(0, 0, 0, 1, 9'h080, 8'h44);
    reset = 1'b1;
    tick();
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    push_cyc_q.delete();
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("in_ready_after_midrst", in_ready, 1);
    tick();
    tick();
    chk("no_stale_out", out_valid, 0);
    lat_check = 1;
    run(0, 0, 0, 0, 9'h0B0, 8'h42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
